// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants and helpers for the pipe_stage_buf slice.
//   SKID_SLOTS  : 1 when the optional skid slot is built (macro PIPE_SKID_EN),
//                 0 otherwise.
//   pipe_cap()  : entries the block can hold for a given number of stages.
//   occ_w()     : width of an occupancy counter able to represent 0..cap.
// -----------------------------------------------------------------------------
package pipe_pkg;

`ifdef PIPE_SKID_EN
  localparam int unsigned SKID_SLOTS = 1;
`else
  localparam int unsigned SKID_SLOTS = 0;
`endif

  function automatic int unsigned pipe_cap(input int unsigned stages);
    return stages + SKID_SLOTS;
  endfunction

  function automatic int unsigned occ_w(input int unsigned cap);
    return (cap < 1) ? 1 : $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One register slot of the pipeline: valid bit plus control and data fields.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (clears everything)
//   flush_i        drop the held entry (valid and control cleared, data kept)
//   load_i         capture ctrl_i/data_i as a new valid entry
//   clear_i        entry leaves with nothing behind it (valid/ctrl cleared)
//   ctrl_i/data_i  incoming fields
//   valid_o/ctrl_o/data_o  held entry
// Data bits only change on a load, so an emptied slot does not toggle its
// wide data field. Control is zeroed whenever the slot becomes a bubble.
// -----------------------------------------------------------------------------
module pipe_slot #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  // NOTE: state is written with non-blocking assignments so every slot
  // samples its neighbour's pre-edge value; blocking here would let an
  // entry race through several slots in one clock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      ctrl_o  <= '0;
      // NOTE: the data field is reset as well so the head reads 0 rather
      // than X straight after reset; it is a few flops, not a memory.
      data_o  <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      ctrl_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      ctrl_o  <= ctrl_i;
      data_o  <= data_i;
    end else if (clear_i) begin
      valid_o <= 1'b0;
      ctrl_o  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
// Multi-stage pipeline register with valid/ready handshake, stall and flush.
// Slot 0 is the entry slot, slot STAGES-1 is the head. Empty slots collapse:
// an entry moves forward whenever the slot ahead is empty or itself moving,
// so bubbles are squeezed out while downstream stalls.
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   flush_i                     discard every in-flight entry at the next edge
//   in_valid_i/in_ready_o       upstream handshake
//   in_ctrl_i/in_data_i         upstream fields
//   out_valid_o/out_ready_i     downstream handshake on the head slot
//   out_ctrl_o                  head control, 0 whenever out_valid_o is 0
//   out_data_o                  head data, holds its last value on a bubble
//   occ_o                       entries currently held (0..CAP)
// Build option: define PIPE_SKID_EN to add a one-entry skid slot in front of
// slot 0. in_ready_o then comes from the skid valid flop instead of rippling
// back from out_ready_i, and CAP becomes STAGES+1.
// -----------------------------------------------------------------------------
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter  int CTRL_W = 2,
  parameter  int DATA_W = 69,
  parameter  int STAGES = 1,
  localparam int CAP    = int'(pipe_cap(STAGES)),
  localparam int OCC_W  = int'(occ_w(CAP))
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [OCC_W-1:0]  occ_o
);

  logic [STAGES-1:0] slot_v;
  logic [STAGES-1:0] slot_open;   // slot can take a new entry this cycle
  logic [CTRL_W-1:0] slot_ctrl [STAGES];
  logic [DATA_W-1:0] slot_data [STAGES];

  logic              in_xfer;
  logic              out_xfer;
  logic              src0_v;      // an entry is offered to slot 0
  logic [CTRL_W-1:0] src0_ctrl;
  logic [DATA_W-1:0] src0_data;
  logic [OCC_W-1:0]  occ_q;

  // A slot is open when it is empty or its occupant moves on this cycle;
  // the head moves on out_ready_i, every other slot moves when the one
  // ahead is open. This ripples from the head back to the entry slot.
  // NOTE: every output of a combinational block gets a value on every path
  // (here the head is assigned first, then each lower slot) so no latch forms.
  always_comb begin
    slot_open[STAGES-1] = ~slot_v[STAGES-1] | out_ready_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      slot_open[k] = ~slot_v[k] | slot_open[k+1];
    end
  end

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

`ifdef PIPE_SKID_EN
  logic              skid_v;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Ready depends only on the skid flop (and flush), never on out_ready_i.
  assign in_ready_o = ~skid_v & ~flush_i;

  // The skid entry is older than anything arriving now, so it has priority
  // into slot 0; input only reaches slot 0 directly while the skid is empty.
  assign src0_v    = skid_v | in_xfer;
  assign src0_ctrl = skid_v ? skid_ctrl : in_ctrl_i;
  assign src0_data = skid_v ? skid_data : in_data_i;

  // An accepted entry parks in the skid when slot 0 is blocked; the skid
  // empties as soon as slot 0 opens. The two never coincide because input
  // is only accepted while the skid is empty.
  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .load_i  (in_xfer & ~slot_open[0]),
    .clear_i (skid_v & slot_open[0]),
    .ctrl_i  (in_ctrl_i),
    .data_i  (in_data_i),
    .valid_o (skid_v),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );
`else
  assign in_ready_o = slot_open[0] & ~flush_i;
  assign src0_v     = in_xfer;
  assign src0_ctrl  = in_ctrl_i;
  assign src0_data  = in_data_i;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic              src_v;
    logic [CTRL_W-1:0] src_ctrl;
    logic [DATA_W-1:0] src_data;

    if (k == 0) begin : g_entry
      assign src_v    = src0_v;
      assign src_ctrl = src0_ctrl;
      assign src_data = src0_data;
    end else begin : g_inner
      assign src_v    = slot_v[k-1];
      assign src_ctrl = slot_ctrl[k-1];
      assign src_data = slot_data[k-1];
    end

    // An open slot with nothing valid behind it becomes a bubble; clearing
    // an already empty slot is harmless.
    pipe_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .load_i  (slot_open[k] & src_v),
      .clear_i (slot_open[k] & ~src_v),
      .ctrl_i  (src_ctrl),
      .data_i  (src_data),
      .valid_o (slot_v[k]),
      .ctrl_o  (slot_ctrl[k]),
      .data_o  (slot_data[k])
    );
  end

  assign out_valid_o = slot_v[STAGES-1];
  assign out_ctrl_o  = out_valid_o ? slot_ctrl[STAGES-1] : '0;
  assign out_data_o  = slot_data[STAGES-1];

  // Occupancy: +1 per accepted entry, -1 per consumed entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  assign occ_o = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
// Bench for pipe_stage_buf with STAGES=3, CTRL_W=2, DATA_W=16.
// The reference model is a queue of in-flight entries, each tagged with its
// position (-1 = skid, 0 = entry slot .. STAGES-1 = head). Each clock an entry
// moves one place forward unless the entry in front stops it.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

  localparam int S  = 3;
  localparam int CW = 2;
  localparam int DW = 16;
`ifdef PIPE_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif
  localparam int CAP_M = S + SKID;
  localparam int OW    = $clog2(CAP_M + 1);

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [OW-1:0] occ;

  pipe_stage_buf #(
    .CTRL_W (CW),
    .DATA_W (DW),
    .STAGES (S)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ctrl_i   (in_ctrl),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ctrl_o  (out_ctrl),
    .out_data_o  (out_data),
    .occ_o       (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            pos;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq[$];
  bit   model_on = 1'b0;
  bit   e_ir;
  bit   e_ov;
  int   popped = 0;

  // Sampled DUT outputs of the current cycle.
  logic          s_ir;
  logic          s_ov;
  logic [CW-1:0] s_oc;
  logic [DW-1:0] s_od;
  logic [OW-1:0] s_occ;

  task automatic model_expect();
    e_ov = (mq.size() > 0) && (mq[0].pos == S - 1);
`ifdef PIPE_SKID_EN
    e_ir = !flush && !((mq.size() > 0) && (mq[mq.size()-1].pos < 0));
`else
    e_ir = !flush && ((mq.size() < S) || out_ready);
`endif
  endtask

  task automatic model_check();
    check("in_ready", 64'(s_ir), 64'(e_ir));
    check("out_valid", 64'(s_ov), 64'(e_ov));
    check("out_ctrl", 64'(s_oc), e_ov ? 64'(mq[0].ctrl) : 64'd0);
    if (e_ov) check("out_data", 64'(s_od), 64'(mq[0].data));
    check("occ", 64'(s_occ), 64'(mq.size()));
    check("occ_bound", 64'(s_occ <= OW'(CAP_M)), 64'd1);
  endtask

  task automatic model_update();
    ent_t e;
    int   lim;
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (e_ov && out_ready) begin
        void'(mq.pop_front());
        popped++;
      end
      if (in_valid && e_ir) begin
        e.pos  = -1;
        e.ctrl = in_ctrl;
        e.data = in_data;
        mq.push_back(e);
      end
      for (int i = 0; i < mq.size(); i++) begin
        e   = mq[i];
        lim = (i == 0) ? S - 1 : mq[i-1].pos - 1;
        e.pos = (e.pos + 1 < lim) ? e.pos + 1 : lim;
        mq[i] = e;
      end
    end
  endtask

  // One clock: drive at negedge, sample and compare 1 ns later, advance the
  // model on the following posedge.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [CW-1:0] c, input logic [DW-1:0] d, input logic o);
    @(negedge clk);
    rst       = r;
    flush     = f;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = o;
    #1;
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_oc  = out_ctrl;
    s_od  = out_data;
    s_occ = occ;
    model_expect();
    if (model_on) model_check();
    @(posedge clk);
    model_update();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          rst;
    logic          fl;
    logic          iv;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic          ordy;
    logic          ir;
    logic          ov;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
    int            occ;
  } tv_t;

  localparam int NTV = 23;
  tv_t tv [NTV];

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;

    //          rst   fl    iv    c      d         ordy  | ir    ov    oc     od        occ
    // reset held with input offered: nothing accepted
    tv[0]  = '{1'b1, 1'b0, 1'b1, 2'd3, 16'h0011, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 0};
    // A, B, C back to back; A reaches the head after 3 cycles
    tv[1]  = '{1'b0, 1'b0, 1'b1, 2'd1, 16'h0001, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 0};
    tv[2]  = '{1'b0, 1'b0, 1'b1, 2'd2, 16'h0002, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 1};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 16'h0003, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 2};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 2'd3, 16'h00ff, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0001, 3};
    // stall: B held at head, slot 0 free so D is taken, E refused
    tv[5]  = '{1'b0, 1'b0, 1'b0, 2'd3, 16'h00ff, 1'b0, 1'b1, 1'b1, 2'd2, 16'h0002, 2};
    tv[6]  = '{1'b0, 1'b0, 1'b1, 2'd3, 16'h0006, 1'b0, 1'b1, 1'b1, 2'd2, 16'h0002, 2};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 16'h0007, 1'b0, 1'b0, 1'b1, 2'd2, 16'h0002, 3};
    // flush a full pipe with input offered; that input never emerges
    tv[8]  = '{1'b0, 1'b1, 1'b1, 2'd3, 16'h0008, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0002, 3};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0002, 0};
    tv[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0002, 0};
    tv[11] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0002, 0};
    tv[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0002, 0};
    // collapse: downstream stalled, two entries with a bubble between
    tv[13] = '{1'b0, 1'b0, 1'b1, 2'd1, 16'h0021, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0002, 0};
    tv[14] = '{1'b0, 1'b0, 1'b0, 2'd3, 16'h0000, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0002, 1};
    tv[15] = '{1'b0, 1'b0, 1'b1, 2'd2, 16'h0022, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0002, 1};
    tv[16] = '{1'b0, 1'b0, 1'b0, 2'd3, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd1, 16'h0021, 2};
    tv[17] = '{1'b0, 1'b0, 1'b1, 2'd3, 16'h0023, 1'b0, 1'b1, 1'b1, 2'd1, 16'h0021, 2};
    tv[18] = '{1'b0, 1'b0, 1'b1, 2'd3, 16'h0024, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0021, 3};
    // drain in order
    tv[19] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0021, 3};
    tv[20] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'd2, 16'h0022, 2};
    tv[21] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'd3, 16'h0023, 1};
    tv[22] = '{1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0023, 0};

    // First cycle: DUT state is unknown until the first reset edge.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    model_on = 1'b1;

`ifndef PIPE_SKID_EN
    for (int i = 0; i < NTV; i++) begin
      step(tv[i].rst, tv[i].fl, tv[i].iv, tv[i].c, tv[i].d, tv[i].ordy);
      check($sformatf("tbl%0d in_ready", i), 64'(s_ir), 64'(tv[i].ir));
      check($sformatf("tbl%0d out_valid", i), 64'(s_ov), 64'(tv[i].ov));
      check($sformatf("tbl%0d out_ctrl", i), 64'(s_oc), 64'(tv[i].oc));
      check($sformatf("tbl%0d out_data", i), 64'(s_od), 64'(tv[i].od));
      check($sformatf("tbl%0d occ", i), 64'(s_occ), 64'(tv[i].occ));
    end
`endif

    // Stream 1..10 back to back with downstream always ready.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    for (int t = 0; t < 14; t++) begin
      step(1'b0, 1'b0, (t < 10), 2'd3, DW'(t + 1), 1'b1);
      if (t < 3) begin
        check($sformatf("stream%0d out_valid", t), 64'(s_ov), 64'd0);
      end else if (t <= 12) begin
        check($sformatf("stream%0d out_valid", t), 64'(s_ov), 64'd1);
        check($sformatf("stream%0d out_data", t), 64'(s_od), 64'(t - 2));
      end
      if (t >= 3 && t <= 10) check($sformatf("stream%0d occ", t), 64'(s_occ), 64'd3);
    end

    // Random traffic: control 2'b11 on every valid cycle for the first part,
    // random control afterwards; rare flushes.
    for (int n = 0; n < 700; n++) begin
      logic          v;
      logic [CW-1:0] c;
      v = ($urandom_range(0, 2) != 0);
      c = (n < 200) ? (v ? 2'b11 : 2'b00) : CW'($urandom);
      step(1'b0, ($urandom_range(0, 49) == 0), v, c, DW'($urandom),
           ($urandom_range(0, 2) != 0));
    end
    check("random_progress", 64'(popped > 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
